// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the data-memory burst master.
//   MEM_AW/MEM_DW/MEM_LW : default address, data and burst-length widths
//   READ_LAT             : data_mem read latency (read_data valid one cycle
//                          after the address is presented)
//   state_t              : burst master FSM encoding
package mem_pkg;
  localparam int MEM_AW   = 8;
  localparam int MEM_DW   = 8;
  localparam int MEM_LW   = 4;
  localparam int READ_LAT = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAPT = 3'd3,
    RD_OUT  = 3'd4
  } state_t;
endpackage

// File: rtl/mem_burst_master.sv
// Initiator for the data memory port. Accepts single/burst fill and read
// commands, runs them as memory cycles and streams read words back.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      command handshake (ready only in IDLE)
//   req_we/addr/len/wdata    command: fill(1)/read(0), start, words-1, fill value
//   resp_valid/ready/data    read-word stream with backpressure
//   busy, done               command in progress, one-cycle completion pulse
//   mem_address/wren/write_data, mem_read_data   data_mem interface
// All outputs come straight from flops.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int LW = MEM_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_address,
  output logic          mem_wren,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data
);

  state_t        state, state_n;
  logic [AW-1:0] cur_addr, addr_n;
  logic [LW-1:0] remaining, rem_n;
  logic [DW-1:0] fill, fill_n, rdata_n;
  logic          wren_n, rvalid_n, done_n;

  // The address counter and latched fill value drive the memory pins
  // directly, so they are registered by construction.
  assign mem_address    = cur_addr;
  assign mem_write_data = fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      fill       <= '0;
      mem_wren   <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      done       <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cur_addr   <= addr_n;
      remaining  <= rem_n;
      fill       <= fill_n;
      mem_wren   <= wren_n;
      resp_valid <= rvalid_n;
      resp_data  <= rdata_n;
      done       <= done_n;
      req_ready  <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so they line up with it after the edge.
  always_comb begin
    state_n  = state;
    addr_n   = cur_addr;
    rem_n    = remaining;
    fill_n   = fill;
    wren_n   = 1'b0;
    rvalid_n = resp_valid;
    rdata_n  = resp_data;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_n = req_addr;
          rem_n  = req_len;
          fill_n = req_wdata;
          if (req_we) begin
            state_n = WR;
            wren_n  = 1'b1;
          end else begin
            state_n = RD_ADDR;
          end
        end
      end
      WR: begin
        if (remaining == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          addr_n = cur_addr + 1'b1;
          rem_n  = remaining - 1'b1;
          wren_n = 1'b1;
        end
      end
      // Address is on the pins during RD_ADDR; data_mem answers one cycle
      // later, which is when RD_CAPT samples it.
      RD_ADDR: state_n = RD_CAPT;
      RD_CAPT: begin
        rdata_n  = mem_read_data;
        rvalid_n = 1'b1;
        state_n  = RD_OUT;
      end
      RD_OUT: begin
        if (resp_ready) begin
          rvalid_n = 1'b0;
          if (remaining == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            addr_n  = cur_addr + 1'b1;
            rem_n   = remaining - 1'b1;
            state_n = RD_ADDR;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
